// File: rtl/jc_pkg.sv
// Shared types and pure code-checking helpers for the Johnson-code receive path.
package jc_pkg;

    localparam int JC_MAX_N = 64;
    localparam int JC_N     = 4;
    localparam int IDX_W    = $clog2(2 * JC_N);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } jc_state_e;

    // A Johnson code has a single 0/1 boundary, so at most one adjacent pair differs.
    function automatic logic jc_legal(input logic [JC_MAX_N-1:0] code, input int n);
        int mm;
        mm = 0;
        for (int i = 0; i < JC_MAX_N - 1; i++) begin
            if (i < n - 1 && code[i] != code[i+1]) mm++;
        end
        return (mm <= 1);
    endfunction

    function automatic int jc_index(input logic [JC_MAX_N-1:0] code, input int n);
        int pc;
        pc = 0;
        for (int i = 0; i < JC_MAX_N; i++) begin
            if (i < n && code[i]) pc++;
        end
        return code[n-1] ? (2 * n - pc) : pc;
    endfunction

endpackage

// File: rtl/jc_code_decode.sv
// Combinational Johnson code decode: legality flag and binary state index.
module jc_code_decode
    import jc_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  jc_i,
    output logic          legal_o,
    output logic [IW-1:0] idx_o
);

    logic [JC_MAX_N-1:0] code_ext;

    assign code_ext = JC_MAX_N'(jc_i);
    assign legal_o  = jc_legal(code_ext, N);
    assign idx_o    = IW'(jc_index(code_ext, N));

endmodule

// File: rtl/johnson_seq_checker.sv
// Johnson code stream checker: decode, sequence lock FSM, error flags and counter.
// Optional JC_DIR_DETECT_EN accepts down-counting and adds a dir output.
module johnson_seq_checker
    import jc_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_RUN = 3,
    parameter int ERR_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              jc_in,
    input  logic                      jc_valid,
    input  logic                      err_clr,
    output logic [$clog2(2*N)-1:0]    bin_out,
    output logic [2*N-1:0]            onehot_out,
    output logic                      dec_valid,
    output logic                      illegal,
    output logic                      seq_err,
    output logic                      locked,
    output logic                      sticky_err,
    output logic [ERR_W-1:0]          err_cnt
`ifdef JC_DIR_DETECT_EN
    ,
    output logic                      dir
`endif
);

    localparam int IW    = $clog2(2 * N);
    localparam int RUN_W = $clog2(LOCK_RUN + 1);
    localparam logic [IW-1:0]    LAST = IW'(2 * N - 1);
    localparam logic [2*N-1:0]   ONE  = (2*N)'(1);
    localparam logic [RUN_W-1:0] LOCK = RUN_W'(LOCK_RUN);

    jc_state_e            state_q, state_d;
    logic [RUN_W-1:0]     run_q, run_d, run_inc;
    logic [IW-1:0]        prev_q, prev_d;
    logic [2*N-1:0]       onehot_q, onehot_d;
    logic                 dv_q, dv_d, ill_q, ill_d, se_q, se_d;
    logic                 sticky_q, sticky_d;
    logic [ERR_W-1:0]     cnt_q, cnt_d;
    logic                 err_ev;

    logic                 legal;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        up_nxt;
    logic                 step_ok, step_rev;

    jc_code_decode #(.N(N), .IW(IW)) u_dec (
        .jc_i    (jc_in),
        .legal_o (legal),
        .idx_o   (idx)
    );

    assign up_nxt  = (prev_q == LAST) ? '0 : prev_q + 1'b1;
    assign run_inc = run_q + 1'b1;

`ifdef JC_DIR_DETECT_EN
    logic          dir_q, dir_d;
    logic [IW-1:0] dn_nxt;
    logic          step_dn;

    assign dn_nxt   = (prev_q == '0) ? LAST : prev_q - 1'b1;
    assign step_dn  = (idx != up_nxt) && (idx == dn_nxt);
    assign step_ok  = (idx == up_nxt) || step_dn;
    assign step_rev = step_ok && (step_dn != dir_q);
    assign dir      = dir_q;
`else
    assign step_ok  = (idx == up_nxt);
    assign step_rev = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        prev_d   = prev_q;
        onehot_d = onehot_q;
        dv_d     = 1'b0;
        ill_d    = 1'b0;
        se_d     = 1'b0;
`ifdef JC_DIR_DETECT_EN
        dir_d    = dir_q;
`endif
        if (jc_valid) begin
            if (!legal) begin
                ill_d   = 1'b1;
                state_d = SEARCH;
                run_d   = '0;
            end else begin
                dv_d     = 1'b1;
                prev_d   = idx;
                onehot_d = ONE << idx;
                unique case (state_q)
                    SEARCH: begin
                        state_d = ACQUIRE;
                        run_d   = '0;
                    end
                    ACQUIRE: begin
                        // The first step after SEARCH has no direction to reverse.
                        if (step_ok && !(step_rev && run_q != '0)) begin
                            run_d = run_inc;
                            if (run_inc == LOCK) state_d = TRACK;
                        end else begin
                            run_d = '0;
                        end
                    end
                    TRACK: begin
                        if (!step_ok || step_rev) begin
                            se_d    = 1'b1;
                            state_d = ACQUIRE;
                            run_d   = '0;
                        end
                    end
                    default: begin
                        state_d = SEARCH;
                        run_d   = '0;
                    end
                endcase
`ifdef JC_DIR_DETECT_EN
                if (state_q != SEARCH && step_ok) dir_d = step_dn;
`endif
            end
        end

        // A clear coinciding with a new error keeps that error.
        err_ev   = ill_d | se_d;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (err_clr) begin
            sticky_d = err_ev;
            cnt_d    = err_ev ? ERR_W'(1) : '0;
        end else if (err_ev) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEARCH;
            run_q    <= '0;
            prev_q   <= '0;
            onehot_q <= '0;
            dv_q     <= 1'b0;
            ill_q    <= 1'b0;
            se_q     <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            prev_q   <= prev_d;
            onehot_q <= onehot_d;
            dv_q     <= dv_d;
            ill_q    <= ill_d;
            se_q     <= se_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef JC_DIR_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) dir_q <= 1'b0;
        else     dir_q <= dir_d;
    end
`endif

    assign bin_out    = prev_q;
    assign onehot_out = onehot_q;
    assign dec_valid  = dv_q;
    assign illegal    = ill_q;
    assign seq_err    = se_q;
    assign locked     = (state_q == TRACK);
    assign sticky_err = sticky_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Directed table-driven bench for johnson_seq_checker (N=4, LOCK_RUN=3, ERR_W=8).
module tb_johnson_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] jc_in = '0;
    logic       jc_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] bin_out;
    logic [7:0] onehot_out;
    logic       dec_valid, illegal, seq_err, locked, sticky_err;
    logic [7:0] err_cnt;
`ifdef JC_DIR_DETECT_EN
    logic       dir;
`endif

    int pass_cnt = 0;
    int total    = 0;

    johnson_seq_checker #(.N(4), .LOCK_RUN(3), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .jc_in      (jc_in),
        .jc_valid   (jc_valid),
        .err_clr    (err_clr),
        .bin_out    (bin_out),
        .onehot_out (onehot_out),
        .dec_valid  (dec_valid),
        .illegal    (illegal),
        .seq_err    (seq_err),
        .locked     (locked),
        .sticky_err (sticky_err),
        .err_cnt    (err_cnt)
`ifdef JC_DIR_DETECT_EN
        ,
        .dir        (dir)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] code;
        logic       clr;
        logic [2:0] bin;
        logic [7:0] oh;
        logic       dv, ill, se, lk;
        logic [7:0] ec;
        logic       st;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] code, input logic clr);
        @(negedge clk);
        jc_valid = v;
        jc_in    = code;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string nm, input logic dv, input logic ill, input logic se,
                             input logic lk, input logic [7:0] ec, input logic st);
        chk({nm, " dec_valid"}, 32'(dec_valid), 32'(dv));
        chk({nm, " illegal"},   32'(illegal),   32'(ill));
        chk({nm, " seq_err"},   32'(seq_err),   32'(se));
        chk({nm, " locked"},    32'(locked),    32'(lk));
        chk({nm, " err_cnt"},   32'(err_cnt),   32'(ec));
        chk({nm, " sticky"},    32'(sticky_err), 32'(st));
    endtask

    initial begin
        //        v  code     clr bin   oh          dv ill se lk ec  st
        vecs[0]  = '{1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 0, 8'd0, 0};
        vecs[1]  = '{1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 0, 0, 8'd0, 0};
        vecs[2]  = '{1, 4'b0011, 0, 3'd2, 8'h04, 1, 0, 0, 0, 8'd0, 0};
        vecs[3]  = '{1, 4'b0111, 0, 3'd3, 8'h08, 1, 0, 0, 1, 8'd0, 0};
        vecs[4]  = '{0, 4'b1010, 0, 3'd3, 8'h08, 0, 0, 0, 1, 8'd0, 0};
        vecs[5]  = '{1, 4'b1111, 0, 3'd4, 8'h10, 1, 0, 0, 1, 8'd0, 0};
        vecs[6]  = '{1, 4'b1110, 0, 3'd5, 8'h20, 1, 0, 0, 1, 8'd0, 0};
        vecs[7]  = '{1, 4'b1100, 0, 3'd6, 8'h40, 1, 0, 0, 1, 8'd0, 0};
        vecs[8]  = '{1, 4'b1000, 0, 3'd7, 8'h80, 1, 0, 0, 1, 8'd0, 0};
        vecs[9]  = '{1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 1, 8'd0, 0};
        vecs[10] = '{1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 0, 1, 8'd0, 0};
        vecs[11] = '{1, 4'b0011, 0, 3'd2, 8'h04, 1, 0, 0, 1, 8'd0, 0};
        vecs[12] = '{1, 4'b0101, 0, 3'd2, 8'h04, 0, 1, 0, 0, 8'd1, 1};
        vecs[13] = '{1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 0, 8'd1, 1};
        vecs[14] = '{1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 0, 0, 8'd1, 1};
        vecs[15] = '{1, 4'b0011, 0, 3'd2, 8'h04, 1, 0, 0, 0, 8'd1, 1};
        vecs[16] = '{1, 4'b0111, 0, 3'd3, 8'h08, 1, 0, 0, 1, 8'd1, 1};
        vecs[17] = '{1, 4'b1100, 0, 3'd6, 8'h40, 1, 0, 1, 0, 8'd2, 1};
        vecs[18] = '{1, 4'b1000, 0, 3'd7, 8'h80, 1, 0, 0, 0, 8'd2, 1};
        vecs[19] = '{1, 4'b0000, 0, 3'd0, 8'h01, 1, 0, 0, 0, 8'd2, 1};
        vecs[20] = '{1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 0, 1, 8'd2, 1};
        vecs[21] = '{0, 4'b0000, 1, 3'd1, 8'h02, 0, 0, 0, 1, 8'd0, 0};
        vecs[22] = '{1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 1, 0, 8'd1, 1};
        vecs[23] = '{1, 4'b0001, 0, 3'd1, 8'h02, 1, 0, 0, 0, 8'd1, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset bin_out", 32'(bin_out), 32'd0);
        chk("reset onehot", 32'(onehot_out), 32'd0);
        chk_flags("reset", 0, 0, 0, 0, 8'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 24; k++) begin
            drive(vecs[k].v, vecs[k].code, vecs[k].clr);
            chk($sformatf("row%0d bin_out", k), 32'(bin_out), 32'(vecs[k].bin));
            chk($sformatf("row%0d onehot", k), 32'(onehot_out), 32'(vecs[k].oh));
            chk_flags($sformatf("row%0d", k), vecs[k].dv, vecs[k].ill, vecs[k].se,
                      vecs[k].lk, vecs[k].ec, vecs[k].st);
        end

        // Saturation: 300 illegal samples starting from err_cnt=1
        for (int i = 0; i < 300; i++) drive(1'b1, 4'b0101, 1'b0);
        chk("sat bin_out", 32'(bin_out), 32'd1);
        chk_flags("sat", 0, 1, 0, 0, 8'd255, 1);
        drive(1'b1, 4'b0101, 1'b1);
        chk_flags("clr+err", 0, 1, 0, 0, 8'd1, 1);
        drive(1'b0, 4'b0000, 1'b1);
        chk_flags("clr only", 0, 0, 0, 0, 8'd0, 0);

        // Reset mid-TRACK with a sticky error pending
        drive(1'b1, 4'b1001, 1'b0);
        chk_flags("pre-rst ill", 0, 1, 0, 0, 8'd1, 1);
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b1, 4'b0011, 1'b0);
        drive(1'b1, 4'b0111, 1'b0);
        chk_flags("pre-rst lock", 1, 0, 0, 1, 8'd1, 1);
        @(negedge clk);
        rst = 1'b1;
        jc_valid = 1'b1;
        jc_in = 4'b1111;
        @(posedge clk);
        #1;
        chk("rst bin_out", 32'(bin_out), 32'd0);
        chk("rst onehot", 32'(onehot_out), 32'd0);
        chk_flags("rst", 0, 0, 0, 0, 8'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'b0000, 1'b0);
        chk_flags("post-rst idle", 0, 0, 0, 0, 8'd0, 0);
        drive(1'b1, 4'b0011, 1'b0);
        chk("post-rst bin", 32'(bin_out), 32'd2);
        chk_flags("post-rst search", 1, 0, 0, 0, 8'd0, 0);

        // Down-counting sequence
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4'b0111, 1'b0);
        drive(1'b1, 4'b0011, 1'b0);
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b1, 4'b0000, 1'b0);
`ifdef JC_DIR_DETECT_EN
        chk("down dir", 32'(dir), 32'd1);
        chk_flags("down", 1, 0, 0, 1, 8'd0, 0);
        drive(1'b1, 4'b0001, 1'b0);
        chk("reverse dir", 32'(dir), 32'd0);
        chk_flags("reverse", 1, 0, 1, 0, 8'd1, 1);
`else
        chk_flags("down", 1, 0, 0, 0, 8'd0, 0);
        drive(1'b1, 4'b0001, 1'b0);
        chk_flags("up after down", 1, 0, 0, 0, 8'd0, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
